sync_fifo_fwft: RTL

Parametrised synchronous first-word-fall-through FIFO, the successor to the current 0-clock-RAM FIFO. It sits between a producer and a consumer in the same clock domain. It uses a 1-clock-read-latency dual-port RAM with a 2-entry prefetch output stage, so the head word is presented with `vld` and can be consumed every cycle. It adds:
- programmable almost-full and almost-empty thresholds
- an occupancy count
- synchronous flush
- sticky overflow/underflow error flags

---
 rtl/fifo_pkg.sv | 14 +
 rtl/ram2p_1clk.sv | 31 +++
 rtl/sync_fifo_fwft.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the first-word-fall-through FIFO family.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Occupancy counters need one extra bit so a completely full FIFO is representable.
    function automatic int fifo_cw(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/ram2p_1clk.sv
// Simple dual-port RAM: one write port, one synchronous read port (data valid the cycle after the address).
module ram2p_1clk #(
    parameter int DW = 24,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Synchronous FWFT FIFO: 1-clock-latency RAM backed by a 2-entry prefetch stage (output + skid register),
// with occupancy count, almost-full/empty thresholds, flush and sticky error flags.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DW = 24,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] data_in,
    output logic          full,
    output logic          al_full,
    input  logic [AW:0]   af_thresh,
    input  logic          pop,
    output logic          vld,
    output logic [DW-1:0] data_out,
    output logic          empty,
    output logic          al_empty,
    input  logic [AW:0]   ae_thresh,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int CW = fifo_cw(AW);
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR1_C  = {{(AW-1){1'b0}}, 1'b1};

    logic          push_acc_s;
    logic          pop_acc_s;
    logic          rd_issue_s;
    logic [1:0]    occ_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] ram_cnt_nxt_s;
    logic [DW-1:0] ram_rd_data_s;

    logic          out_vld_nxt_s;
    logic [DW-1:0] out_data_nxt_s;
    logic          skid_vld_nxt_s;
    logic [DW-1:0] skid_data_nxt_s;

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] ram_cnt_r;
    logic [CW-1:0] count_r;
    logic          inflight_r;
    logic          out_vld_r;
    logic [DW-1:0] out_data_r;
    logic          skid_vld_r;
    logic [DW-1:0] skid_data_r;
    logic          full_r;
    logic          empty_r;
    logic          al_full_r;
    logic          al_empty_r;
    fifo_err_t     err_r;

    // Acceptance and prefetch decisions; occupancy is counted after this cycle's pop so streaming has no bubbles.
    always_comb begin
        push_acc_s = push && !full_r && !flush;
        pop_acc_s  = pop && out_vld_r && !flush;
        occ_s      = {1'b0, out_vld_r} + {1'b0, skid_vld_r} + {1'b0, inflight_r};
        rd_issue_s = !flush && (ram_cnt_r != ZERO_C) && ((occ_s - {1'b0, pop_acc_s}) < 2'd2);
    end

    // Next occupancy of the whole FIFO and of the RAM alone.
    always_comb begin
        count_nxt_s   = count_r;
        ram_cnt_nxt_s = ram_cnt_r;
        if (flush) begin
            count_nxt_s   = ZERO_C;
            ram_cnt_nxt_s = ZERO_C;
        end else begin
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_nxt_s = count_r + ONE_C;
                2'b01:   count_nxt_s = count_r - ONE_C;
                default: count_nxt_s = count_r;
            endcase
            case ({push_acc_s, rd_issue_s})
                2'b10:   ram_cnt_nxt_s = ram_cnt_r + ONE_C;
                2'b01:   ram_cnt_nxt_s = ram_cnt_r - ONE_C;
                default: ram_cnt_nxt_s = ram_cnt_r;
            endcase
        end
    end

    // Prefetch stage: the skid word refills the output first so ordering is kept when a read also lands.
    always_comb begin
        out_vld_nxt_s   = out_vld_r;
        out_data_nxt_s  = out_data_r;
        skid_vld_nxt_s  = skid_vld_r;
        skid_data_nxt_s = skid_data_r;
        if (pop_acc_s) begin
            if (skid_vld_r) begin
                out_vld_nxt_s  = 1'b1;
                out_data_nxt_s = skid_data_r;
                if (inflight_r) begin
                    skid_data_nxt_s = ram_rd_data_s;
                end else begin
                    skid_vld_nxt_s = 1'b0;
                end
            end else if (inflight_r) begin
                out_data_nxt_s = ram_rd_data_s;
            end else begin
                out_vld_nxt_s = 1'b0;
            end
        end else if (inflight_r) begin
            if (!out_vld_r) begin
                out_vld_nxt_s  = 1'b1;
                out_data_nxt_s = ram_rd_data_s;
            end else begin
                skid_vld_nxt_s  = 1'b1;
                skid_data_nxt_s = ram_rd_data_s;
            end
        end else begin
            out_vld_nxt_s = out_vld_r;
        end
    end

    ram2p_1clk #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push_acc_s),
        .wr_addr(wr_ptr_r),
        .wr_data(data_in),
        .rd_en  (rd_issue_s),
        .rd_addr(rd_ptr_r),
        .rd_data(ram_rd_data_s)
    );

    // Pointers, occupancy counters and the in-flight read marker.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            ram_cnt_r  <= ZERO_C;
            count_r    <= ZERO_C;
            inflight_r <= 1'b0;
        end else begin
            wr_ptr_r   <= push_acc_s ? wr_ptr_r + PTR1_C : wr_ptr_r;
            rd_ptr_r   <= rd_issue_s ? rd_ptr_r + PTR1_C : rd_ptr_r;
            ram_cnt_r  <= ram_cnt_nxt_s;
            count_r    <= count_nxt_s;
            inflight_r <= rd_issue_s;
        end
    end

    // Output and skid registers.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_vld_r   <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            skid_vld_r  <= 1'b0;
            skid_data_r <= {DW{1'b0}};
        end else begin
            out_vld_r   <= out_vld_nxt_s;
            out_data_r  <= out_data_nxt_s;
            skid_vld_r  <= skid_vld_nxt_s;
            skid_data_r <= skid_data_nxt_s;
        end
    end

    // Status flags decoded from the count being registered this edge (zero during reset/flush).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            al_full_r  <= (ZERO_C >= af_thresh);
            al_empty_r <= 1'b1;
        end else begin
            full_r     <= (count_nxt_s == DEPTH_C);
            empty_r    <= (count_nxt_s == ZERO_C);
            al_full_r  <= (count_nxt_s >= af_thresh);
            al_empty_r <= (count_nxt_s <= ae_thresh);
        end
    end

    // Sticky error flags survive flush; requests in a flush cycle are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= '{overflow: 1'b0, underflow: 1'b0};
        end else begin
            err_r.overflow  <= err_r.overflow  | (push && full_r && !flush);
            err_r.underflow <= err_r.underflow | (pop && !out_vld_r && !flush);
        end
    end

    assign full      = full_r;
    assign empty     = empty_r;
    assign al_full   = al_full_r;
    assign al_empty  = al_empty_r;
    assign count     = count_r;
    assign vld       = out_vld_r;
    assign data_out  = out_data_r;
    assign overflow  = err_r.overflow;
    assign underflow = err_r.underflow;

endmodule
